// File: rtl/sw_debounce_sync_pkg.sv
// Shared definitions for the slide-switch conditioner: per-bit FSM encoding,
// board timing constants and the counter-width legality rule.
package sw_debounce_sync_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } dbState_e;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 20;

  // 20 ms of CLOCK_50 cycles, the settle time a switch level must hold
  localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  function automatic bit cntWidthOk(input int cycles, input int cntW);
    return (cycles >= 2) && (cntW > 0) && (cntW < 63) &&
           ((64'd1 << cntW) > 64'(cycles));
  endfunction

endpackage

// File: rtl/sw_debounce_sync_bit.sv
// One switch bit: two-flop synchroniser, qualification counter, two-state
// FSM and registered edge pulses.
module debounce_bit
  import sw_debounce_sync_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  dbState_e         state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             db_q;
  logic             rise_q;
  logic             fall_q;

  // The counter tracks how many consecutive samples sync2 has disagreed with
  // the accepted level; any agreeing sample is a bounce and restarts it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sync2_q != db_q) begin
            state_q <= CHECK;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        CHECK: begin
          if (sync2_q == db_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            db_q    <= sync2_q;
            rise_q  <= sync2_q;
            fall_q  <= ~sync2_q;
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/sw_debounce_sync.sv
// Conditions the raw slide switches for the 2-to-1 switch mux: each bit is
// synchronised and debounced on its own, with per-bit edge pulses.
module sw_debounce_sync
  import sw_debounce_sync_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_DB,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL
);

  // A counter too narrow to reach DEBOUNCE_CYCLES-1 would wrap, so refuse it
  if (!cntWidthOk(DEBOUNCE_CYCLES, CNT_W)) begin : gen_bad_cfg
    $error("sw_debounce_sync: CNT_W too small or DEBOUNCE_CYCLES < 2");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk_i (CLOCK_50),
      .rst_i (Reset),
      .sw_i  (SW[i]),
      .db_o  (SW_DB[i]),
      .rise_o(SW_RISE[i]),
      .fall_o(SW_FALL[i])
    );
  end

endmodule
